fmap_sram_reader: RTL and testbench

- Read-side sequencer for the two-port feature-map SRAM; drives its read port (chip enable, address) and captures its read data.
- On a start pulse it streams a contiguous block of words (base, length) out as a valid/ready stream to the PE array input.
- Absorbs the SRAM's 1-cycle read latency with a 2-entry output buffer, so backpressure never loses or duplicates data.
- Sustains 1 word/cycle while out_ready is high.

---
 rtl/fmap_sram_reader_pkg.sv | 12 +
 rtl/fmap_sram_reader_if.sv | 13 +
 rtl/fmap_skid_fifo2.sv | 68 ++++++
 rtl/fmap_sram_reader.sv | 119 +++++++++++
 tb/tb_fmap_sram_reader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_sram_reader_pkg.sv
// Shared constants for the feature-map SRAM sequencers: data width and the
// read/write sequencer state encodings.
package fmap_sram_reader_pkg;

    localparam int unsigned INTERNAL_BITS = 16;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_DRAIN      = 2'd2;
    localparam logic [1:0] ST_DONE_PULSE = 2'd3;

endpackage

// File: rtl/fmap_sram_reader_if.sv
// Valid/ready word stream from the feature-map reader to the PE array input.
interface fmap_sram_reader_if;
    import fmap_sram_reader_pkg::*;

    logic [INTERNAL_BITS-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/fmap_skid_fifo2.sv
// 2-entry FIFO with a last tag; an arriving word is visible at the head in the same
// cycle when the FIFO is empty, and is stored only if it is not consumed immediately.
module fmap_skid_fifo2
    import fmap_sram_reader_pkg::*;
#(
    parameter int unsigned DATA_BITS = INTERNAL_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic                 head_valid,
    output logic [DATA_BITS-1:0] head_data,
    output logic                 head_last,
    output logic [1:0]           count
);

    logic [DATA_BITS-1:0] data_q [2];
    logic [1:0]           last_q;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic                 bypass, wr_en, rd_en;

    always_comb begin
        bypass     = (count_q == 2'd0) && push;
        head_valid = (count_q != 2'd0) || push;
        head_data  = bypass ? push_data : data_q[rd_ptr_q];
        head_last  = bypass ? push_last : last_q[rd_ptr_q];
        // A bypassed word popped in its arrival cycle never touches storage
        wr_en      = push && !(bypass && pop);
        rd_en      = pop && (count_q != 2'd0);
        count_d    = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (wr_en) begin
                data_q[wr_ptr_q] <= push_data;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count = count_q;

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/fmap_sram_reader.sv
// Read-side sequencer for the feature-map SRAM: streams a (base, length) block of
// words, absorbing the one-cycle read latency in a 2-entry skid FIFO.
module fmap_sram_reader
    import fmap_sram_reader_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 13,
    parameter int unsigned MEM_SIZE  = 8192
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [ADDR_BITS:0]       length,
    output logic                     busy,
    output logic                     done,
    output logic                     sram_cen,
    output logic [ADDR_BITS-1:0]     sram_addr,
    input  logic [INTERNAL_BITS-1:0] sram_q,
    fmap_sram_reader_if.master       strm
);

    localparam logic [ADDR_BITS:0] LEN_ONE = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS:0] MAX_LEN = (ADDR_BITS + 1)'(MEM_SIZE);

    logic [1:0]               state_q, state_d;
    logic [ADDR_BITS-1:0]     base_q;
    logic [ADDR_BITS:0]       len_q;
    logic [ADDR_BITS:0]       issued_q;
    logic                     inflight_q, inflight_last_q;

    logic                     pop, issue, last_issue, accept;
    logic [2:0]               occ;
    logic [1:0]               fifo_count;
    logic                     head_valid, head_last;
    logic [INTERNAL_BITS-1:0] head_data;

    always_comb begin
        pop        = head_valid && strm.out_ready;
        // Words that will still be held after this cycle: buffered + arriving - leaving
        occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == ST_RUN) && (issued_q < len_q) && (occ < 3'd2);
        last_issue = issue && (issued_q == len_q - LEN_ONE);
        accept     = (state_q == ST_IDLE) && start;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? ST_DONE_PULSE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ == 3'd0) begin
                    state_d = ST_DONE_PULSE;
                end
            end
            ST_DONE_PULSE: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            if (accept) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + LEN_ONE;
            end
        end
    end

    // Capture is unconditional: QA is only guaranteed the cycle after a read
    fmap_skid_fifo2 #(
        .DATA_BITS (INTERNAL_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_data  (sram_q),
        .push_last  (inflight_last_q),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_last  (head_last),
        .count      (fifo_count)
    );

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE_PULSE);
    assign sram_cen  = issue;
    assign sram_addr = base_q + issued_q[ADDR_BITS-1:0];

    assign strm.out_valid = head_valid;
    assign strm.out_data  = head_data;
    assign strm.out_last  = head_valid && head_last;

    length_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (length <= MAX_LEN));

endmodule

// File: tb/tb_fmap_sram_reader.sv
// Directed bench for fmap_sram_reader: SRAM model with mem[a] = {3'b101, a}, stream
// monitor on the falling edge, and hand-computed expectations per block.
module tb_fmap_sram_reader;
    import fmap_sram_reader_pkg::*;

    localparam int unsigned AB = 13;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [AB-1:0]            base_addr = '0;
    logic [AB:0]              length = '0;
    logic                     busy, done, sram_cen;
    logic [AB-1:0]            sram_addr;
    logic [INTERNAL_BITS-1:0] sram_q;
    logic [INTERNAL_BITS-1:0] mem [8192];

    fmap_sram_reader_if strm_if ();

    fmap_sram_reader #(
        .ADDR_BITS (AB),
        .MEM_SIZE  (8192)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_addr (sram_addr),
        .sram_q    (sram_q),
        .strm      (strm_if)
    );

    initial forever #5 clk = ~clk;

    // SRAM read port: QA updates only on a read, holds otherwise
    always @(posedge clk) if (sram_cen) sram_q <= mem[sram_addr];

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int n_cen, n_xfer, done_cnt, cap_err, hold_err, cen_pre8, busy_cnt;
    int start_cyc, first_valid_cyc, first_cen_cyc, last_xfer_cyc, done_cyc;
    logic                     hold_pend;
    logic [INTERNAL_BITS-1:0] hold_data;
    logic [INTERNAL_BITS-1:0] got_data [$];
    logic                     got_last [$];
    logic [AB-1:0]            addr_log [$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        got_data.delete();
        got_last.delete();
        addr_log.delete();
        n_cen = 0; n_xfer = 0; done_cnt = 0; cap_err = 0; hold_err = 0;
        cen_pre8 = 0; busy_cnt = 0; hold_pend = 1'b0; hold_data = '0;
        first_valid_cyc = -1; first_cen_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    endtask

    // Stream/SRAM monitor, sampled mid-cycle
    initial forever begin
        logic pop;
        @(negedge clk);
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            pop = strm_if.out_valid && strm_if.out_ready;
            if (sram_cen) begin
                if ((n_cen - n_xfer - (pop ? 1 : 0)) >= 2) cap_err++;
                if (first_cen_cyc < 0) first_cen_cyc = cyc;
                if ((cyc - start_cyc) < 8) cen_pre8++;
                addr_log.push_back(sram_addr);
                n_cen++;
            end
            if (strm_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pop) begin
                got_data.push_back(strm_if.out_data);
                got_last.push_back(strm_if.out_last);
                last_xfer_cyc = cyc;
                n_xfer++;
            end
            if (hold_pend && !(strm_if.out_valid && strm_if.out_data == hold_data)) hold_err++;
            hold_pend = strm_if.out_valid && !strm_if.out_ready;
            hold_data = strm_if.out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    // Called at posedge+1; start is high for the cycle numbered 0
    task automatic run_block(input logic [AB-1:0] b, input logic [AB:0] n,
                             input logic [31:0] rmask, input bit restart);
        clear_logs();
        base_addr = b;
        length = n;
        start = 1'b1;
        strm_if.out_ready = rmask[0];
        start_cyc = cyc;
        for (int k = 1; k < 200; k++) begin
            @(posedge clk);
            #1;
            start = restart && (k == 2);
            if (restart && k == 2) begin
                base_addr = 13'h0500;
                length = 14'd3;
            end
            strm_if.out_ready = (k < 32) ? rmask[k] : 1'b1;
            if (done_cnt > 0 && cyc > done_cyc + 2) break;
        end
        start = 1'b0;
        strm_if.out_ready = 1'b1;
    endtask

    task automatic verify(input string tag, input logic [AB-1:0] b, input int n);
        check_eq({tag, "_words"}, got_data.size(), n);
        check_eq({tag, "_reads"}, addr_log.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            logic [AB-1:0] a;
            a = b + 13'(i);
            check_eq($sformatf("%s_data%0d", tag, i), got_data[i], {3'b101, a});
            check_eq($sformatf("%s_last%0d", tag, i), got_last[i], (i == n - 1));
        end
        for (int i = 0; i < n && i < addr_log.size(); i++) begin
            logic [AB-1:0] a;
            a = b + 13'(i);
            check_eq($sformatf("%s_addr%0d", tag, i), addr_log[i], a);
        end
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_capacity"}, cap_err, 0);
        check_eq({tag, "_hold"}, hold_err, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = {3'b101, 13'(i)};
        strm_if.out_ready = 1'b1;
        start_cyc = 0;
        clear_logs();
        #12;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cen", sram_cen, 0);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_valid", strm_if.out_valid, 0);
        check_eq("rst_last", strm_if.out_last, 0);
        check_eq("rst_data", strm_if.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic block, ready held high
        run_block(13'h0010, 14'd4, 32'hFFFF_FFFF, 1'b0);
        verify("basic", 13'h0010, 4);
        check_eq("basic_first_cen", first_cen_cyc - start_cyc, 1);
        check_eq("basic_first_valid", first_valid_cyc - start_cyc, 2);
        check_eq("basic_last_xfer", last_xfer_cyc - start_cyc, 5);
        check_eq("basic_done_cyc", done_cyc - start_cyc, 6);
        check_eq("basic_busy_cycles", busy_cnt, 5);
        check_eq("basic_word0", got_data[0], 16'hA010);
        check_eq("basic_word3", got_data[3], 16'hA013);

        // Address wrap past the top of the SRAM
        run_block(13'h1FFE, 14'd4, 32'hFFFF_FFFF, 1'b0);
        verify("wrap", 13'h1FFE, 4);
        check_eq("wrap_addr2", addr_log[2], 13'h0000);
        check_eq("wrap_word1", got_data[1], 16'hBFFF);
        check_eq("wrap_word2", got_data[2], 16'hA000);

        // Stall cycles 3..7: only reads at cycles 1..3 may issue before the stall ends
        run_block(13'h0300, 14'd8, ~32'h0000_00F8, 1'b0);
        verify("stall", 13'h0300, 8);
        check_eq("stall_cen_pre8", cen_pre8, 3);

        // Ready toggling every cycle
        run_block(13'h0400, 14'd6, 32'h5555_5555, 1'b0);
        verify("toggle", 13'h0400, 6);

        // Zero-length block
        run_block(13'h0020, 14'd0, 32'hFFFF_FFFF, 1'b0);
        check_eq("zero_reads", n_cen, 0);
        check_eq("zero_words", got_data.size(), 0);
        check_eq("zero_done_cnt", done_cnt, 1);
        check_eq("zero_done_cyc", done_cyc - start_cyc, 1);
        check_eq("zero_busy", busy_cnt, 0);

        // Second start while busy is dropped
        run_block(13'h0200, 14'd5, 32'hFFFF_FFFF, 1'b1);
        verify("restart", 13'h0200, 5);

        // Reset after the second word of a 6-word block
        clear_logs();
        base_addr = 13'h0040;
        length = 14'd6;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50 && n_xfer < 2; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("midrst_reached", n_xfer, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_cen", sram_cen, 0);
        check_eq("midrst_addr", sram_addr, 0);
        check_eq("midrst_valid", strm_if.out_valid, 0);
        check_eq("midrst_last", strm_if.out_last, 0);
        check_eq("midrst_data", strm_if.out_data, 0);
        check_eq("midrst_no_done", done_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_block(13'h0100, 14'd3, 32'hFFFF_FFFF, 1'b0);
        verify("postrst", 13'h0100, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
